// File: rtl/perceptron_pkg.sv
// Shared widths, weight limits, FSM encoding and sample record for the perceptron and its trainer.
package perceptron_pkg;

    localparam int N_IN = 16;
    localparam int W_W  = 4;
    localparam int AW   = $clog2(N_IN + 1);

    // The bias weight sits just past the last feature weight.
    localparam logic [AW-1:0] BIAS_ADDR = AW'(N_IN);

    localparam logic signed [W_W-1:0] W_MAX = {1'b0, {(W_W-1){1'b1}}};
    localparam logic signed [W_W-1:0] W_MIN = {1'b1, {(W_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } state_t;

    typedef struct packed {
        logic [N_IN-1:0] x;
        logic            target;
        logic            pred;
    } sample_t;

    // Learning-rule error: +1, 0 or -1 as a 2-bit signed value.
    function automatic logic signed [1:0] calc_err(input logic target, input logic pred);
        return $signed({1'b0, target}) - $signed({1'b0, pred});
    endfunction

endpackage

// File: rtl/perceptron_trainer_if.sv
// Sample channel plus weight-file read/write port between the trainer (slave) and its environment (master).
interface perceptron_trainer_if;

    logic                                  sample_valid;
    logic                                  sample_ready;
    logic [perceptron_pkg::N_IN-1:0]       sample_x;
    logic                                  sample_target;
    logic                                  sample_pred;

    logic [perceptron_pkg::AW-1:0]         w_rd_addr;
    logic signed [perceptron_pkg::W_W-1:0] w_rd_data;
    logic                                  w_wr_en;
    logic [perceptron_pkg::AW-1:0]         w_wr_addr;
    logic signed [perceptron_pkg::W_W-1:0] w_wr_data;

    modport master (
        output sample_valid, sample_x, sample_target, sample_pred, w_rd_data,
        input  sample_ready, w_rd_addr, w_wr_en, w_wr_addr, w_wr_data
    );

    modport slave (
        input  sample_valid, sample_x, sample_target, sample_pred, w_rd_data,
        output sample_ready, w_rd_addr, w_wr_en, w_wr_addr, w_wr_data
    );

endinterface

// File: rtl/perceptron_sat_step.sv
// Combinational weight step: w + err evaluated one bit wider, clamped to [W_MIN, W_MAX].
module perceptron_sat_step
    import perceptron_pkg::*;
(
    input  logic signed [W_W-1:0] w,
    input  logic signed [1:0]     err,
    output logic signed [W_W-1:0] w_next
);

    logic [W_W:0] sum;
    logic         ovf;

    assign sum = {w[W_W-1], w} + {{(W_W-1){err[1]}}, err};

    // Top two bits disagree only when the true result left the W_W-bit range.
    assign ovf = sum[W_W] ^ sum[W_W-1];

    always_comb begin
        w_next = sum[W_W-1:0];
        if (ovf) begin
            w_next = sum[W_W] ? W_MIN : W_MAX;
        end
    end

endmodule

// File: rtl/perceptron_trainer.sv
// Perceptron learning rule as read-modify-write over the weight file; done in 1 cycle (err==0) or 2*(N_IN+1)+1.
// sample_ready is high only when idle; valid offered while busy is ignored, never queued.
module perceptron_trainer
    import perceptron_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    perceptron_trainer_if.slave bus,
    output logic                upd_done,
    output logic [15:0]         err_count
);

    state_t                state;
    state_t                state_nxt;
    sample_t               smp;
    logic [AW-1:0]         idx;

    logic                  ready;
    logic                  accept;
    logic                  err_nz;
    logic [N_IN:0]         x_ext;
    logic                  x_bit;
    logic signed [1:0]     err;
    logic signed [1:0]     step;
    logic signed [W_W-1:0] w_new;
    logic                  wr_req;
    logic                  done_req;

    assign ready  = (state == IDLE) && !rst;
    assign accept = bus.sample_valid && ready;
    assign err_nz = bus.sample_target ^ bus.sample_pred;

    // Bias input is a constant 1, so the bias weight always moves when err != 0.
    assign x_ext = {1'b1, smp.x};
    assign x_bit = x_ext[idx];
    assign err   = calc_err(smp.target, smp.pred);
    assign step  = x_bit ? err : 2'sd0;

    perceptron_sat_step u_sat (
        .w      (bus.w_rd_data),
        .err    (step),
        .w_next (w_new)
    );

    always_comb begin
        state_nxt = state;
        wr_req    = 1'b0;
        done_req  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = err_nz ? RD : DONE;
                end
            end
            RD: begin
                state_nxt = WR;
            end
            WR: begin
                wr_req    = (w_new != bus.w_rd_data);
                state_nxt = (idx == BIAS_ADDR) ? DONE : RD;
            end
            DONE: begin
                done_req  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            smp       <= '0;
            err_count <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                smp <= '{x: bus.sample_x, target: bus.sample_target, pred: bus.sample_pred};
                idx <= '0;
                if (err_nz && (err_count != 16'hFFFF)) begin
                    err_count <= err_count + 16'd1;
                end
            end else if ((state == WR) && (idx != BIAS_ADDR)) begin
                idx <= idx + AW'(1);
            end
        end
    end

    // Strobes are masked by rst so an abort never lets a write through in the reset cycle.
    assign bus.sample_ready = ready;
    assign bus.w_rd_addr    = idx;
    assign bus.w_wr_en      = wr_req && !rst;
    assign bus.w_wr_addr    = idx;
    assign bus.w_wr_data    = w_new;
    assign upd_done         = done_req && !rst;

endmodule
